// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: digit count and the
// active-low hex segment table (bit0 = a ... bit6 = g).
package seg7_pkg;

    localparam int SEG7_DIGITS = 8;

    localparam logic [6:0] SEG7_OFF = 7'h7F;

    localparam logic [6:0] SEG7_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-segment decoder, active-low outputs.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG7_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit common-anode hex display driver with frame-aligned shadow capture.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN turns off anodes of leading-zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIV       = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic [7:0]  dp_i,
    input  logic        freeze_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      shadow;
    logic [7:0]       dp_sh;

    logic       tick;
    logic       frame_end;
    logic       blank;
    logic       hide_digit;
    logic [3:0] nibble;
    logic [6:0] seg_dec;

    assign tick      = (cnt == CNT_MAX);
    assign frame_end = tick && (idx == 3'(SEG7_DIGITS - 1));
    assign blank     = (cnt < BLANK_LIM);
    assign nibble    = shadow[{idx, 2'b00} +: 4];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit k is a leading zero when every nibble from k upward is zero.
    assign hide_digit = (idx != 3'd0) && ((shadow >> {idx, 2'b00}) == 32'd0);
`else
    assign hide_digit = 1'b0;
`endif

    hex_to_seg7 u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            dp_sh  <= '0;
            an_o   <= 8'hFF;
            seg_o  <= SEG7_OFF;
            dp_o   <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= idx + 3'd1;
            end
            // Shadow reloads on the same edge that idx wraps to 0, so a frame never tears.
            if (frame_end && !freeze_i) begin
                shadow <= data_i;
                dp_sh  <= dp_i;
            end
            // Output stage: one cycle behind cnt/idx.
            an_o  <= (blank || hide_digit) ? 8'hFF : ~(8'b1 << idx);
            seg_o <= seg_dec;
            dp_o  <= blank ? 1'b1 : ~dp_sh[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIV=4, BLANK_CYC=1): per-cycle reference model,
// decoder table vectors, and directed multi-cycle sequences.
module tb_seg7_scan_driver;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 8 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  dp;
    logic        freeze;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp_out;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .data_i   (data),
        .dp_i     (dp),
        .freeze_i (freeze),
        .an_o     (an),
        .seg_o    (seg),
        .dp_o     (dp_out)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: absolute position within the frame plus the captured value.
    int          t_m     = 0;
    int          t_shown = -1;
    logic [31:0] sh_m    = '0;
    logic [7:0]  dps_m   = '0;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } dec_vec_t;

    dec_vec_t dec_tab [16];

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int         pos;
        int         dig;
        logic       lz;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (rst) begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            pos = t_m % DIV;
            dig = (t_m / DIV) % 8;
            lz  = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            lz = (dig != 0) && ((sh_m >> (4 * dig)) == 32'd0);
`endif
            e_an = 8'hFF;
            if (!(pos < BLANK) && !lz) e_an[dig] = 1'b0;
            e_seg = ref_seg(sh_m[4*dig +: 4]);
            e_dp  = (pos < BLANK) ? 1'b1 : ~dps_m[dig];
        end
        @(posedge clk);
        if (rst) begin
            t_m     = 0;
            t_shown = -1;
            sh_m    = '0;
            dps_m   = '0;
        end else begin
            if (t_m == FRAME - 1 && !freeze) begin
                sh_m  = data;
                dps_m = dp;
            end
            t_shown = t_m;
            t_m     = (t_m + 1) % FRAME;
        end
        #1;
        check("model_an", an, e_an);
        check("model_seg", seg, e_seg);
        check("model_dp", dp_out, e_dp);
    endtask

    // Advance at least one cycle, until the outputs show slot s (lit or blank part).
    task automatic goto_slot(input int s, input bit lit);
        int target;
        int n;
        target = s * DIV + (lit ? BLANK : 0);
        n = 0;
        do begin
            step();
            n++;
        end while (t_shown != target && n < 3 * FRAME);
        if (t_shown != target) begin
            checks++;
            failures++;
            $display("FAIL goto_slot actual=%0d required=%0d", t_shown, target);
        end
    endtask

    logic [6:0] dead_seg [8];

    initial begin
        dec_tab = '{
            '{4'h0, 7'b1000000}, '{4'h1, 7'b1111001}, '{4'h2, 7'b0100100}, '{4'h3, 7'b0110000},
            '{4'h4, 7'b0011001}, '{4'h5, 7'b0010010}, '{4'h6, 7'b0000010}, '{4'h7, 7'b1111000},
            '{4'h8, 7'b0000000}, '{4'h9, 7'b0010000}, '{4'hA, 7'b0001000}, '{4'hB, 7'b0000011},
            '{4'hC, 7'b1000110}, '{4'hD, 7'b0100001}, '{4'hE, 7'b0000110}, '{4'hF, 7'b0001110}
        };
        // digit 0..7 of DEADBEEF: F,E,E,b,d,A,E,d
        dead_seg = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011,
                     7'b0100001, 7'b0001000, 7'b0000110, 7'b0100001};

        rst = 1'b1; data = 32'hFFFF_FFFF; dp = 8'h00; freeze = 1'b0;

        // Reset held 3 cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_an", an, 8'hFF);
            check("rst_seg", seg, 7'h7F);
            check("rst_dp", dp_out, 1'b1);
        end
        rst = 1'b0;
        step();
        check("post_rst_blank_an", an, 8'hFF);
        step();
        check("post_rst_d0_an", an, 8'hFE);
        check("post_rst_d0_seg", seg, 7'b1000000);

        // 12345678 with dp on digit 0, shown in the following frame.
        data = 32'h1234_5678; dp = 8'h01;
        goto_slot(0, 0);
        check("s0_blank_an", an, 8'hFF);
        step();
        check("s0_an", an, 8'hFE);
        check("s0_seg", seg, 7'b0000000);
        check("s0_dp", dp_out, 1'b0);
        goto_slot(7, 0);
        check("s7_blank_an", an, 8'hFF);
        step();
        check("s7_an", an, 8'h7F);
        check("s7_seg", seg, 7'b1111001);
        check("s7_dp", dp_out, 1'b1);

        // Freeze holds the old value across several frames.
        freeze = 1'b1; data = 32'hDEAD_BEEF; dp = 8'h00;
        for (int i = 0; i < 3 * FRAME; i++) step();
        goto_slot(0, 1);
        check("frz_s0_seg", seg, 7'b0000000);
        goto_slot(7, 1);
        check("frz_s7_seg", seg, 7'b1111001);
        freeze = 1'b0;
        goto_slot(0, 1);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) goto_slot(k, 1);
            check("unfrz_seg", seg, dead_seg[k]);
        end

        // Mid-frame data change must not tear the current frame.
        data = 32'hAAAA_AAAA;
        goto_slot(0, 1);
        goto_slot(3, 1);
        check("mid_a3_seg", seg, 7'b0001000);
        data = 32'h5555_5555;
        for (int k = 4; k < 8; k++) begin
            goto_slot(k, 1);
            check("mid_a_seg", seg, 7'b0001000);
        end
        goto_slot(0, 1);
        check("mid_5_seg", seg, 7'b0010010);

        // Reset pulse during slot 5.
        goto_slot(5, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("pulse_an", an, 8'hFF);
        step();
        check("pulse_blank_an", an, 8'hFF);
        step();
        check("pulse_d0_an", an, 8'hFE);
        check("pulse_d0_seg", seg, 7'b1000000);
        goto_slot(3, 1);
        check("pulse_d3_seg", seg, 7'b1000000);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        data = 32'h0000_0A0F;
        goto_slot(0, 1);
        goto_slot(0, 1);
        check("lz_d0_an", an, 8'hFE);
        check("lz_d0_seg", seg, 7'b0001110);
        goto_slot(2, 1);
        check("lz_d2_an", an, 8'hFB);
        goto_slot(3, 1);
        check("lz_d3_an", an, 8'hFF);
        data = 32'h0;
        goto_slot(0, 1);
        goto_slot(0, 1);
        check("lz0_d0_seg", seg, 7'b1000000);
        goto_slot(1, 1);
        check("lz0_d1_an", an, 8'hFF);
`else
        data = 32'h0000_0A0F;
        goto_slot(0, 1);
        goto_slot(3, 1);
        check("nolz_d3_an", an, 8'hF7);
        check("nolz_d3_seg", seg, 7'b1000000);
`endif

        // Decoder table, every nibble in every digit position.
        for (int v = 0; v < 16; v++) begin
            data = {8{dec_tab[v].nib}};
            goto_slot(0, 1);
            goto_slot(0, 1);
            check("dec_d0_seg", seg, dec_tab[v].seg);
            goto_slot(6, 1);
            check("dec_d6_seg", seg, dec_tab[v].seg);
        end

        // Randomized run against the reference model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) data = $urandom;
            if ($urandom_range(0, 7) == 0) dp = 8'($urandom);
            freeze = ($urandom_range(0, 3) == 0);
            rst    = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
